// File: rtl/melody_sequencer.sv
// Plays a fixed note table through the tone mux. Each note is held for a number of beat ticks
// and followed by an optional silent gap. The whole song is repeated REPEATS times per start.
module melody_sequencer #(
   parameter int unsigned TICK_DIV  = 6_250_000,
   parameter int unsigned GAP_TICKS = 1,
   parameter int unsigned REPEATS   = 3
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic       stop_i,
   input  logic       mute_i,
   output logic [2:0] sel_o,
   output logic       note_en_o,
   output logic       busy_o,
   output logic       done_o
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
   localparam int unsigned RW = (REPEATS > 1) ? $clog2(REPEATS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [2:0]      idx_q, idx_d;
   logic [RW-1:0]   pass_q, pass_d;
   logic [3:0]      rem_q, rem_d;
   logic [GW-1:0]   gap_q, gap_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [2:0]      sel_q, sel_d;
   logic            note_en_q, note_en_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic            tick;
   logic            advance;
   logic [2:0]      nxt_idx;
   logic [6:0]      nxt_ent;
   logic [6:0]      ent0;

   // Song ROM: {note[2:0], dur[3:0]}; dur == 0 terminates the song.
   function automatic logic [6:0] rom(input logic [2:0] i);
      case (i)
         3'd0:    rom = {3'd3, 4'd2};
         3'd1:    rom = {3'd5, 4'd2};
         3'd2:    rom = {3'd1, 4'd4};
         default: rom = {3'd0, 4'd0};
      endcase
   endfunction

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         pass_q    <= '0;
         rem_q     <= '0;
         gap_q     <= '0;
         presc_q   <= '0;
         sel_q     <= '0;
         note_en_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         pass_q    <= pass_d;
         rem_q     <= rem_d;
         gap_q     <= gap_d;
         presc_q   <= presc_d;
         sel_q     <= sel_d;
         note_en_q <= note_en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      pass_d    = pass_q;
      rem_d     = rem_q;
      gap_d     = gap_q;
      presc_d   = presc_q;
      sel_d     = sel_q;
      done_d    = 1'b0;
      advance   = 1'b0;
      tick      = (presc_q == PW'(TICK_DIV - 1));
      nxt_idx   = idx_q + 3'd1;
      nxt_ent   = rom(nxt_idx);
      ent0      = rom(3'd0);

      case (state_q)
         IDLE: begin
            if (start_i) begin
               presc_d = '0;
               idx_d   = '0;
               pass_d  = '0;
               if (ent0[3:0] != 4'd0) begin
                  state_d = PLAY;
                  sel_d   = ent0[6:4];
                  rem_d   = ent0[3:0];
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         PLAY: begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
               rem_d = rem_q - 4'd1;
               if (rem_q == 4'd1) begin
                  if (GAP_TICKS > 0) begin
                     state_d = GAP;
                     gap_d   = GW'(GAP_TICKS);
                  end else begin
                     advance = 1'b1;
                  end
               end
            end
         end
         GAP: begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
               gap_d = gap_q - GW'(1);
               if (gap_q == GW'(1)) begin
                  advance = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Step to the next table entry, wrapping to a new pass or finishing at end of song.
      if (advance) begin
         if (nxt_ent[3:0] != 4'd0) begin
            state_d = PLAY;
            idx_d   = nxt_idx;
            sel_d   = nxt_ent[6:4];
            rem_d   = nxt_ent[3:0];
         end else if (pass_q < RW'(REPEATS - 1)) begin
            state_d = PLAY;
            pass_d  = pass_q + RW'(1);
            idx_d   = '0;
            sel_d   = ent0[6:4];
            rem_d   = ent0[3:0];
         end else begin
            state_d = IDLE;
            sel_d   = '0;
            presc_d = '0;
            done_d  = 1'b1;
         end
      end

      if (stop_i) begin
         state_d = IDLE;
         sel_d   = '0;
         presc_d = '0;
         done_d  = 1'b0;
      end

      busy_d    = (state_d != IDLE);
      note_en_d = (state_d == PLAY) && !mute_i;
   end

   assign sel_o     = sel_q;
   assign note_en_o = note_en_q;
   assign busy_o    = busy_q;
   assign done_o    = done_q;

endmodule
